ysyx_24110015_ifu: RTL and testbench

Instruction fetch unit of the NPC core: owns the PC, issues one instruction-memory read at a time, and hands each fetched instruction with its PC to the decode stage over a valid/ready handshake. It sits directly upstream of the decoder, whose opcode/funct selection is built from the key-driven mux selectors. It accepts PC redirects from execute/writeback and discards any fetch made obsolete by a redirect.

---
 rtl/ysyx_24110015_ifu_pkg.sv | 15 +
 rtl/ysyx_24110015_MuxKeyWithDefault.sv | 25 ++
 rtl/ysyx_24110015_Reg.sv | 21 ++
 rtl/ysyx_24110015_ifu.sv | 116 +++++++++++
 tb/tb_ysyx_24110015_ifu.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24110015_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the NOP word shown before the first fetch, and the default boot PC.
package ysyx_24110015_ifu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } ifu_state_e;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24110015_MuxKeyWithDefault.sv
// Key-matched lookup mux: each lut entry is {key, data}; unmatched keys
// select default_out.
module ysyx_24110015_MuxKeyWithDefault #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   input  logic [KEY_LEN-1:0]                  key,
   input  logic [DATA_LEN-1:0]                 default_out,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
   output logic [DATA_LEN-1:0]                 out
);

   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

   always_comb begin
      out = default_out;
      for (int i = 0; i < NR_KEY; i++) begin
         if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
            out = lut[i*PAIR_LEN +: DATA_LEN];
         end
      end
   end

endmodule

// File: rtl/ysyx_24110015_Reg.sv
// Generic register with write enable and asynchronous active-low reset.
module ysyx_24110015_Reg #(
   parameter int                 WIDTH     = 1,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= RESET_VAL;
      end else if (wen) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight and
// hands each fetched word to decode; redirects squash obsolete fetches.
module ysyx_24110015_ifu
   import ysyx_24110015_ifu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            imem_resp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            out_fault,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   ifu_state_e      state_q, state_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] pc_plus4;
   logic            redir;
   logic            handoff;
   logic            accept;

   assign redir           = redirect_valid && (state_q != S_IDLE);
   assign handoff         = (state_q == S_HOLD) && out_ready;
   assign accept          = (state_q == S_WAIT) && imem_resp_valid && !drop_q && !redirect_valid;
   assign redirect_target = redirect_pc & ~XLEN'(3);
   assign pc_plus4        = pc_q + XLEN'(4);

   // A redirect wins over a same-cycle handoff, so the +4 never applies to it.
   ysyx_24110015_MuxKeyWithDefault #(
      .NR_KEY   (3),
      .KEY_LEN  (2),
      .DATA_LEN (XLEN)
   ) u_next_pc_mux (
      .key         ({redir, handoff}),
      .default_out (pc_q),
      .lut         ({2'b11, redirect_target,
                     2'b10, redirect_target,
                     2'b01, pc_plus4}),
      .out         (pc_d)
   );

   ysyx_24110015_Reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
      .clk (clk), .rst_n (rst_n), .wen (1'b1), .din (pc_d), .dout (pc_q)
   );

   ysyx_24110015_Reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_out_pc_reg (
      .clk (clk), .rst_n (rst_n), .wen (accept), .din (pc_q), .dout (out_pc)
   );

   ysyx_24110015_Reg #(.WIDTH(32), .RESET_VAL(NOP_INST)) u_out_inst_reg (
      .clk (clk), .rst_n (rst_n), .wen (accept), .din (imem_resp_data), .dout (out_inst)
   );

   ysyx_24110015_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_out_fault_reg (
      .clk (clk), .rst_n (rst_n), .wen (accept), .din (imem_resp_err), .dout (out_fault)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // drop marks an in-flight read whose response must be swallowed.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_WAIT;
               drop_d  = redir;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               drop_d  = 1'b0;
               state_d = (redir || drop_q) ? S_REQ : S_HOLD;
            end else if (redir) begin
               drop_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redir || out_ready) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req_valid = (state_q == S_REQ);
      imem_req_addr  = pc_q;
      out_valid      = (state_q == S_HOLD);
   end

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Scoreboard bench for the fetch unit: a stimulus process models memory and
// the architectural PC stream, a monitor checks every presented instruction.
module tb_ysyx_24110015_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [31:0] model_pc;
   bit          seen_req;
   bit          pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   int          resp_delay;

   logic        prev_valid;
   logic [31:0] prev_pc;
   logic [31:0] prev_inst;
   logic        prev_fault;
   int          idle_cycles;

   always #5 clk = ~clk;

   ysyx_24110015_ifu dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .out_fault       (out_fault),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   function automatic logic [31:0] memData(input logic [31:0] a);
      if (a == RESET_PC) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic memErr(input logic [31:0] a);
      return a[7:2] == 6'd5;
   endfunction

   function automatic exp_t mkExp(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.inst  = memData(pc);
      e.fault = memErr(pc);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic resetModel();
      exp_q.delete();
      model_pc = RESET_PC;
      exp_q.push_back(mkExp(model_pc));
      seen_req = 1'b0;
   endtask

   // One cycle of stimulus: memory responder, request acceptance and the
   // architectural PC model that feeds the expected-instruction queue.
   task automatic applyStimulus(input bit req_rdy, input bit o_rdy, input bit redir,
                                input logic [31:0] target);
      @(negedge clk);
      #1;
      if (pend && pend_cnt == 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memData(pend_addr);
         imem_resp_err   = memErr(pend_addr);
         pend            = 1'b0;
      end else begin
         if (pend) pend_cnt--;
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
         imem_resp_err   = 1'($urandom_range(0, 1));
      end
      if (imem_req_valid) seen_req = 1'b1;
      imem_req_ready = req_rdy;
      if (imem_req_valid && req_rdy) begin
         checkOutput("req_addr", imem_req_addr, model_pc);
         checkOutput("one_outstanding", 32'(pend), 32'd0);
         pend      = 1'b1;
         pend_addr = imem_req_addr;
         pend_cnt  = resp_delay;
      end
      out_ready      = o_rdy;
      redirect_valid = redir;
      redirect_pc    = target;
      if (redir && seen_req) begin
         model_pc = target & 32'hFFFF_FFFC;
         exp_q.delete();
         exp_q.push_back(mkExp(model_pc));
      end else if (out_valid && o_rdy) begin
         model_pc = model_pc + 32'd4;
         exp_q.push_back(mkExp(model_pc));
      end
   endtask

   task automatic waitForReq();
      int n = 0;
      do begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         n++;
      end while (!imem_req_valid && n < 20);
      checkOutput("req_seen", 32'(imem_req_valid), 32'd1);
   endtask

   task automatic waitForValid();
      int n = 0;
      do begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         n++;
      end while (!out_valid && n < 20);
      checkOutput("valid_seen", 32'(out_valid), 32'd1);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_pc", out_pc, RESET_PC);
      checkOutput("rst_out_inst", out_inst, NOP);
      checkOutput("rst_out_fault", 32'(out_fault), 32'd0);
   endtask

   // Monitor: pops one expected entry per new presentation and checks that a
   // held instruction stays put until consumed or withdrawn.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid  = 1'b0;
         idle_cycles = 0;
      end else begin
         if (out_valid) begin
            checkOutput("no_req_in_hold", 32'(imem_req_valid), 32'd0);
            idle_cycles = 0;
         end
         if (prev_valid && !out_ready && !redirect_valid) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_pc", out_pc, prev_pc);
            checkOutput("hold_inst", out_inst, prev_inst);
            checkOutput("hold_fault", 32'(out_fault), 32'(prev_fault));
         end else if (prev_valid) begin
            checkOutput("release_valid", 32'(out_valid), 32'd0);
         end else if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got pc %h expected none", out_pc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("sb_pc", out_pc, e.pc);
               checkOutput("sb_inst", out_inst, e.inst);
               checkOutput("sb_fault", 32'(out_fault), 32'(e.fault));
            end
         end else begin
            idle_cycles++;
            if (idle_cycles > 400) begin
               checks++;
               errors++;
               $display("[TB] FAIL fetch_timeout: got no output for %0d cycles expected fewer", idle_cycles);
               idle_cycles = 0;
            end
         end
         prev_valid = out_valid;
         prev_pc    = out_pc;
         prev_inst  = out_inst;
         prev_fault = out_fault;
      end
   end

   initial begin
      rst_n           = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
      out_ready       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      pend            = 1'b0;
      pend_cnt        = 0;
      pend_addr       = 32'h0;
      resp_delay      = 0;
      resetModel();

      repeat (2) @(negedge clk);
      #1;
      checkResetValues();
      // Release into IDLE with a redirect that must be ignored.
      rst_n          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1234;

      // Zero-wait memory, decode always ready.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("first_req_addr", imem_req_addr, RESET_PC);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("wait_no_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("first_valid", 32'(out_valid), 32'd1);
      checkOutput("first_pc", out_pc, RESET_PC);
      checkOutput("first_inst", out_inst, 32'h0010_0093);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("next_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("next_req_addr", imem_req_addr, 32'h8000_0004);

      // Decode stalls for 5 cycles.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("stall_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_no_req", 32'(imem_req_valid), 32'd0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect while waiting on a slow response.
      resp_delay = 2;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0102);
      resp_delay = 0;
      waitForReq();
      checkOutput("redir_wait_addr", imem_req_addr, 32'h8000_0100);

      // Redirect in the same cycle as the response.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0040);
      waitForReq();
      checkOutput("redir_resp_addr", imem_req_addr, 32'h8000_0040);

      // Access fault, then a clean fetch at pc+4.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0014);
      waitForReq();
      checkOutput("fault_req_addr", imem_req_addr, 32'h8000_0014);
      waitForValid();
      checkOutput("fault_pc", out_pc, 32'h8000_0014);
      checkOutput("fault_flag", 32'(out_fault), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      waitForValid();
      checkOutput("after_fault_pc", out_pc, 32'h8000_0018);
      checkOutput("after_fault_flag", 32'(out_fault), 32'd0);

      // Withdraw in HOLD via redirect to the top of the address space, then wrap.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      waitForReq();
      checkOutput("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      waitForValid();
      checkOutput("top_pc", out_pc, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      waitForReq();
      checkOutput("wrap_req_addr", imem_req_addr, 32'h0000_0000);

      // Reset pulsed during WAIT; the late response must be ignored.
      resp_delay = 3;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      resetModel();
      #1;
      checkResetValues();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("restart_req_addr", imem_req_addr, RESET_PC);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("late_resp_ignored", 32'(out_valid), 32'd0);
      resp_delay = 0;
      waitForValid();
      checkOutput("restart_pc", out_pc, RESET_PC);
      checkOutput("restart_inst", out_inst, 32'h0010_0093);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         resp_delay = $urandom_range(0, 3);
         applyStimulus($urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) != 0,
                       $urandom_range(0, 11) == 0,
                       32'h8000_0000 | ($urandom & 32'h0000_03FF));
      end
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
